// File: rtl/dcr_pkg.sv
// dcr_pkg: shared constants and state type for the receiver front end
package dcr_pkg;
    localparam int FRAME_BITS = 32;
    localparam int FEC_REP = 3;
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'h0000;
    typedef enum logic {RECV, DONE} dcr_state_t;
endpackage

// File: rtl/crc16_serial.sv
// crc16_serial: bit-serial CRC-16/XMODEM, MSB first, updated while enabled
module crc16_serial
    import dcr_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        bit_in,
    output logic [15:0] crc
);
    // shift in one bit per enabled edge, folding in the polynomial on feedback
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) crc <= CRC_INIT;
        else if (enable) crc <= {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? CRC_POLY : 16'h0);
endmodule

// File: rtl/dcr_main.sv
// dcr_main: frame deserializer with running CRC-16 and repetition-FEC image (FEC register built only with DCR_FEC_EN)
module dcr_main #(
    parameter int FRAME_BITS = dcr_pkg::FRAME_BITS
) (
    input  logic                                 clck,
    input  logic                                 start,
    input  logic                                 x,
    output logic [dcr_pkg::FEC_REP*FRAME_BITS-1:0] out,
    output logic [dcr_pkg::FEC_REP*FRAME_BITS-1:0] fec,
    output logic [15:0]                          crc,
    output logic                                 status
);
    import dcr_pkg::*;
    localparam int W = FEC_REP * FRAME_BITS;
    localparam int CW = $clog2(FRAME_BITS);
    dcr_state_t state, next_state;
    logic [CW-1:0] cnt;
    logic recv, last;
    assign recv = (state == RECV);
    assign last = recv && (cnt == CW'(FRAME_BITS - 1));
    assign status = (state == DONE);
    // state register; DONE is only left through reset
    always_ff @(posedge clck or negedge start)
        if (!start) state <= RECV;
        else state <= next_state;
    // advance to DONE on the edge that samples the final bit
    always_comb next_state = last ? DONE : state;
    // count sampled bits while receiving
    always_ff @(posedge clck or negedge start)
        if (!start) cnt <= '0;
        else if (recv) cnt <= cnt + 1'b1;
    // shift window takes a bit every receiving edge and freezes in DONE
    always_ff @(posedge clck or negedge start)
        if (!start) out <= '0;
        else if (recv) out <= {out[W-2:0], x};
    crc16_serial u_crc (
        .clk    (clck),
        .rst_n  (start),
        .enable (recv),
        .bit_in (x),
        .crc    (crc)
    );
`ifdef DCR_FEC_EN
    logic [FRAME_BITS-1:0] d;
    logic [W-1:0] rep, fec_q;
    assign d = {out[FRAME_BITS-2:0], x};
    for (genvar i = 0; i < FRAME_BITS; i++) begin : g_rep
        assign rep[FEC_REP*i +: FEC_REP] = {FEC_REP{d[i]}};
    end
    // capture the expanded frame together with the last bit
    always_ff @(posedge clck or negedge start)
        if (!start) fec_q <= '0;
        else if (last) fec_q <= rep;
    assign fec = fec_q;
`else
    assign fec = '0;
`endif
endmodule

// File: tb/tb_dcr_main.sv
// tb_dcr_main: directed self-checking bench for dcr_main
module tb_dcr_main;
    logic clck = 1'b0;
    logic start = 1'b0;
    logic x = 1'b0;
    logic [95:0] out, fec;
    logic [15:0] crc;
    logic status;
    int checks = 0;
    int failures = 0;

    dcr_main dut (.clck(clck), .start(start), .x(x), .out(out), .fec(fec), .crc(crc), .status(status));

    always #5 clck = ~clck;

    function automatic logic [15:0] xmodem(input logic [31:0] w, input int nbytes);
        logic [15:0] c = 16'h0000;
        for (int b = 0; b < nbytes; b++) begin
            c = c ^ {w[31-8*b -: 8], 8'h00};
            for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [95:0] exp_fec(input logic [95:0] v);
`ifdef DCR_FEC_EN
        return v;
`else
        return 96'h0;
`endif
    endfunction

    // all tasks start and end just after a falling edge
    task automatic send_bits(input logic [31:0] w, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            x = w[31-i];
            @(posedge clck);
            @(negedge clck);
        end
    endtask

    task automatic do_reset();
        start = 1'b0;
        @(posedge clck);
        @(negedge clck);
        start = 1'b1;
    endtask

    task automatic chk96(input string nm, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic test_reset();
        start = 1'b0;
        x = 1'b1;
        repeat (3) @(posedge clck);
        @(negedge clck);
        chk96("reset_out", out, 96'h0);
        chk96("reset_fec", fec, 96'h0);
        chk16("reset_crc", crc, 16'h0);
        chk16("reset_status", {15'h0, status}, 16'h0);
        start = 1'b1;
    endtask

    task automatic test_frame(input string nm, input logic [31:0] w, input logic [95:0] f);
        do_reset();
        send_bits(w, 0, 8);
        chk96({nm, "_out8"}, out, {88'h0, w[31:24]});
        chk16({nm, "_crc8"}, crc, xmodem(w, 1));
        send_bits(w, 8, 31);
        chk16({nm, "_status31"}, {15'h0, status}, 16'h0);
        chk96({nm, "_fec31"}, fec, 96'h0);
        send_bits(w, 31, 32);
        chk16({nm, "_status"}, {15'h0, status}, 16'h1);
        chk96({nm, "_out"}, out, {64'h0, w});
        chk96({nm, "_fec"}, fec, exp_fec(f));
        chk16({nm, "_crc"}, crc, xmodem(w, 4));
    endtask

    task automatic test_done_hold();
        test_frame("hold_pre", 32'h0301_0203, 96'h00003F000007000038_00003F);
        for (int i = 0; i < 10; i++) begin
            x = i[0];
            @(posedge clck);
            @(negedge clck);
        end
        chk96("hold_out", out, 96'h0000_0000_0000_0000_0301_0203);
        chk96("hold_fec", fec, exp_fec(96'h00003F000007000038_00003F));
        chk16("hold_crc", crc, xmodem(32'h0301_0203, 4));
        chk16("hold_status", {15'h0, status}, 16'h1);
    endtask

    task automatic test_async_reset();
        do_reset();
        send_bits(32'hFFFF_FFFF, 0, 16);
        #2 start = 1'b0;
        #1;
        chk96("async_out", out, 96'h0);
        chk16("async_crc", crc, 16'h0);
        chk16("async_status", {15'h0, status}, 16'h0);
        @(negedge clck);
        start = 1'b1;
        send_bits(32'h0000_0001, 0, 31);
        chk16("async_status31", {15'h0, status}, 16'h0);
        send_bits(32'h0000_0001, 31, 32);
        chk16("async_status32", {15'h0, status}, 16'h1);
        chk16("async_crc32", crc, 16'h1021);
        chk96("async_out32", out, 96'h1);
        chk96("async_fec32", fec, exp_fec(96'h7));
    endtask

    initial begin
        @(negedge clck);
        test_reset();
        test_frame("f03010203", 32'h0301_0203, 96'h00003F000007000038_00003F);
        test_frame("f00000001", 32'h0000_0001, 96'h7);
        test_frame("fzero", 32'h0000_0000, 96'h0);
        test_frame("fones", 32'hFFFF_FFFF, {96{1'b1}});
        test_done_hold();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
